axil_rr_replayer: RTL and testbench
===================================

Name: axil_rr_replayer

Overview:
- Replay-side counterpart of the AXI-Lite record path. Consumes logged master-input packets (header plus AW/W/AR payloads) from the replay log stream.
- Re-drives those packets as an AXI-Lite master toward the CL-side slave port, for sh_ocl, sh_bar1 and sda_cl.
- Preserves inter-packet ordering and bounds outstanding transactions.
- Sinks B/R responses and exposes them for the replay checker.

Parameters:
- MAX_OUTSTANDING, 4: max issued-but-unanswered writes (AW-to-B) and, separately, reads (AR-to-R); range 1..15.
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- replay_en  in  1  permits acceptance of new log packets
- log_valid  in  1  log packet valid
- log_ready  out  1  log packet accepted
- log_pkt  in  103  packed {hdr[2:0]={hasAW,hasW,hasAR}, awaddr[31:0], wdata[31:0], wstrb[3:0], araddr[31:0]}, MSB first
- awaddr/awvalid  out  32/1; awready  in  1
- wdata/wstrb/wvalid  out  32/4/1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1
- araddr/arvalid  out  32/1; arready  in  1
- rdata  in  32; rresp  in  2; rvalid  in  1; rready  out  1
- rsp_valid  out  1  one-cycle pulse per B or R response
- rsp_is_read  out  1; rsp_data  out  32 (0 for B); rsp_resp  out  2
- pkt_cnt  out  CNT_W  packets fully replayed
- wr_outstanding, rd_outstanding  out  4 each

Behaviour:
- Reset (async assert, sync release): all valids 0; bready and rready 0 while rst_n is low, 1 from the first cycle after release; log_ready 0; all counters and outstanding counts 0; payload registers 0; FSM IDLE.
- FSM IDLE:
  - log_ready = replay_en.
  - On log_valid & log_ready: latch payload; set pend_aw/pend_w/pend_ar from hdr.
  - If hdr == 3'b000: pkt_cnt+1, stay IDLE. Otherwise go to ISSUE.
- FSM ISSUE:
  - log_ready = 0.
  - awvalid = pend_aw & (wr_outstanding < MAX_OUTSTANDING).
  - wvalid = pend_w.
  - arvalid = pend_ar & (rd_outstanding < MAX_OUTSTANDING).
  - Each pend bit clears on its own handshake. Channels are independent within a packet; AW and W may complete in either order.
  - When the last pend bit clears, pkt_cnt+1 and return to IDLE.
  - The next packet is accepted no earlier than the following cycle (1 idle bubble; throughput ≤ 1 packet / 2 cycles).
- Once asserted, a valid holds with stable payload until handshake. AXI rule: valid never depends on ready.
- replay_en deassert mid-ISSUE: the current packet completes; no new packet is accepted.
- Outstanding counts:
  - wr_outstanding +1 on AW handshake, −1 on B handshake; simultaneous events leave it unchanged. rd_outstanding likewise with AR/R.
  - At MAX_OUTSTANDING, the respective valid is suppressed until a response arrives.
  - A response arriving while the count is 0 is a protocol error: ignore the decrement (saturate at 0) and still forward it on rsp_*.
- Responses:
  - bready = rready = 1 after reset.
  - rsp_* is registered, 1-cycle latency after the B/R handshake.
  - If B and R handshake in the same cycle: R is forwarded that cycle and B is held in a 1-entry buffer, forwarded next cycle. While that buffer is occupied, bready = 0.
- pkt_cnt wraps modulo 2^CNT_W.

Optional Feature:
- Macro: AXIL_RR_REPLAY_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [CNT_W-1:0], incremented per B/R response with resp != 2'b00.
  - Adds output err_sticky, set on the first such response and cleared only by reset.
  - A B error and an R error in the same cycle add 2.
- Undefined: neither port exists; no logic is generated.

Decomposition:
- Package cl_fpgarr_pkg gains:
  - typedef axil_rr_mstr_hdr {hasAW, hasW, hasAR}.
  - typedef axil_rr_pkt {axil_rr_mstr_hdr, axil_rr_AW, axil_rr_W, axil_rr_AR}.
  - localparam AXIL_RR_PKT_W = 103.
  - localparam AXIL_RESP_OKAY = 2'b00.
- Sub-module axil_rr_outstanding_ctr (inc/dec/limit, saturating, parameterised MAX), instantiated twice.

Test Plan:
- Packet hdr=111, awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, araddr=0x20; ready=1 on all channels -> AW/W/AR valid in the same cycle, one cycle each; pkt_cnt=1; log_ready returns 1 two cycles after accept.
- hdr=110, awready held 0 for 5 cycles, wready=1 -> W completes at once; awvalid held 5 cycles with awaddr stable; packet 2 not accepted until AW completes.
- MAX_OUTSTANDING=2, four hdr=100 packets, no B -> awvalid stays low on the 3rd packet, wr_outstanding=2; one B (bresp=00) -> 3rd AW issues next cycle.
- B and R valid in the same cycle (bresp=00, rresp=00, rdata=0x1234) -> rsp_valid for R (rsp_data=0x1234), then B next cycle; bready=0 for one cycle.
- hdr=000 packet -> no channel activity, pkt_cnt+1, log_ready stays 1; rst_n asserted mid-ISSUE -> all valids 0 immediately, counters 0.
- With AXIL_RR_REPLAY_ERR_CNT_EN: bresp=10 and rresp=11 in the same cycle -> err_cnt=2, err_sticky=1; a later OKAY response leaves both unchanged.

Source files
------------

// File: rtl/cl_fpgarr_pkg.sv
// Shared types for the FPGA record/replay AXI-Lite paths: logged master
// packet layout, response codes and replayer FSM states.
package cl_fpgarr_pkg;

  localparam int         AXIL_RR_PKT_W  = 103;
  localparam logic [1:0] AXIL_RESP_OKAY = 2'b00;

  typedef struct packed {
    logic has_aw;
    logic has_w;
    logic has_ar;
  } axil_rr_mstr_hdr;

  typedef struct packed {
    logic [31:0] awaddr;
  } axil_rr_AW;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } axil_rr_W;

  typedef struct packed {
    logic [31:0] araddr;
  } axil_rr_AR;

  // Field order matches the log stream, MSB first.
  typedef struct packed {
    axil_rr_mstr_hdr hdr;
    axil_rr_AW       aw;
    axil_rr_W        w;
    axil_rr_AR       ar;
  } axil_rr_pkt;

  typedef enum logic {
    RR_IDLE  = 1'b0,
    RR_ISSUE = 1'b1
  } axil_rr_state_e;

endpackage

// File: rtl/axil_rr_outstanding_ctr.sv
// Issued-but-unanswered transaction counter: +1 on request handshake, -1 on
// response handshake, never below zero; avail_o gates new requests at MAX.
module axil_rr_outstanding_ctr #(
  parameter int MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] count_o,
  output logic       avail_o
);

  localparam logic [3:0] MAX_C = 4'(MAX);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + 4'd1;
    end else if (dec_i && !inc_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign avail_o = (count_q < MAX_C);

endmodule

// File: rtl/axil_rr_replayer.sv
// Replays logged AXI-Lite master packets onto the CL slave port and sinks
// B/R responses. Optional error statistics under AXIL_RR_REPLAY_ERR_CNT_EN.
module axil_rr_replayer
  import cl_fpgarr_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     replay_en,
  input  logic                     log_valid,
  output logic                     log_ready,
  input  logic [AXIL_RR_PKT_W-1:0] log_pkt,
  output logic [31:0]              awaddr,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [31:0]              araddr,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic                     rsp_valid,
  output logic                     rsp_is_read,
  output logic [31:0]              rsp_data,
  output logic [1:0]               rsp_resp,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic [3:0]               wr_outstanding,
  output logic [3:0]               rd_outstanding
`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     err_sticky
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  axil_rr_pkt     pkt_in;
  axil_rr_state_e state_q;
  logic           live_q;
  logic           pend_aw_q, pend_w_q, pend_ar_q;
  logic           pend_aw_d, pend_w_d, pend_ar_d;
  logic [31:0]    awaddr_q, wdata_q, araddr_q;
  logic [3:0]     wstrb_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic           wr_avail, rd_avail;
  logic           aw_hs, w_hs, ar_hs, b_hs, r_hs, accept;

  logic           bbuf_valid_q;
  logic [1:0]     bbuf_resp_q;
  logic           rsp_valid_q, rsp_is_read_q;
  logic [31:0]    rsp_data_q;
  logic [1:0]     rsp_resp_q;

  assign pkt_in = axil_rr_pkt'(log_pkt);

  // live_q keeps every ready low until the first cycle after reset release.
  assign log_ready = live_q && (state_q == RR_IDLE) && replay_en;
  assign bready    = live_q && !bbuf_valid_q;
  assign rready    = live_q;

  assign awvalid = pend_aw_q && wr_avail;
  assign wvalid  = pend_w_q;
  assign arvalid = pend_ar_q && rd_avail;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign b_hs   = bvalid && bready;
  assign r_hs   = rvalid && rready;
  assign accept = log_valid && log_ready;

  assign pend_aw_d = pend_aw_q && !aw_hs;
  assign pend_w_d  = pend_w_q && !w_hs;
  assign pend_ar_d = pend_ar_q && !ar_hs;

  axil_rr_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_wr_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (aw_hs),
    .dec_i   (b_hs),
    .count_o (wr_outstanding),
    .avail_o (wr_avail)
  );

  axil_rr_outstanding_ctr #(.MAX(MAX_OUTSTANDING)) u_rd_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (ar_hs),
    .dec_i   (r_hs),
    .count_o (rd_outstanding),
    .avail_o (rd_avail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RR_IDLE;
      live_q    <= 1'b0;
      pend_aw_q <= 1'b0;
      pend_w_q  <= 1'b0;
      pend_ar_q <= 1'b0;
      // NOTE: payload registers are reset too, so the bus never shows X before the first packet.
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      live_q <= 1'b1;
      if (state_q == RR_IDLE) begin
        if (accept) begin
          awaddr_q  <= pkt_in.aw.awaddr;
          wdata_q   <= pkt_in.w.wdata;
          wstrb_q   <= pkt_in.w.wstrb;
          araddr_q  <= pkt_in.ar.araddr;
          pend_aw_q <= pkt_in.hdr.has_aw;
          pend_w_q  <= pkt_in.hdr.has_w;
          pend_ar_q <= pkt_in.hdr.has_ar;
          if (pkt_in.hdr == 3'b000) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
          end else begin
            state_q <= RR_ISSUE;
          end
        end
      end else begin
        pend_aw_q <= pend_aw_d;
        pend_w_q  <= pend_w_d;
        pend_ar_q <= pend_ar_d;
        if (!(pend_aw_d || pend_w_d || pend_ar_d)) begin
          pkt_cnt_q <= pkt_cnt_q + CNT_ONE;
          state_q   <= RR_IDLE;
        end
      end
    end
  end

  // R wins a same-cycle collision; B waits one cycle in the buffer with bready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbuf_valid_q  <= 1'b0;
      bbuf_resp_q   <= AXIL_RESP_OKAY;
      rsp_valid_q   <= 1'b0;
      rsp_is_read_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= AXIL_RESP_OKAY;
    end else begin
      rsp_valid_q <= 1'b0;
      if (r_hs) begin
        rsp_valid_q   <= 1'b1;
        rsp_is_read_q <= 1'b1;
        rsp_data_q    <= rdata;
        rsp_resp_q    <= rresp;
        if (b_hs) begin
          bbuf_valid_q <= 1'b1;
          bbuf_resp_q  <= bresp;
        end
      end else if (bbuf_valid_q) begin
        rsp_valid_q   <= 1'b1;
        rsp_is_read_q <= 1'b0;
        rsp_data_q    <= '0;
        rsp_resp_q    <= bbuf_resp_q;
        bbuf_valid_q  <= 1'b0;
      end else if (b_hs) begin
        rsp_valid_q   <= 1'b1;
        rsp_is_read_q <= 1'b0;
        rsp_data_q    <= '0;
        rsp_resp_q    <= bresp;
      end
    end
  end

  assign awaddr      = awaddr_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign araddr      = araddr_q;
  assign pkt_cnt     = pkt_cnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_is_read = rsp_is_read_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;

`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
  logic             b_err, r_err;
  logic [CNT_W-1:0] err_inc;
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_sticky_q;

  // Counted at the handshake, so a B/R error pair adds 2 in one cycle.
  assign b_err   = b_hs && (bresp != AXIL_RESP_OKAY);
  assign r_err   = r_hs && (rresp != AXIL_RESP_OKAY);
  assign err_inc = CNT_W'({b_err && r_err, b_err ^ r_err});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_q + err_inc;
      if (b_err || r_err) begin
        err_sticky_q <= 1'b1;
      end
    end
  end

  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_axil_rr_replayer.sv
// Self-checking bench for axil_rr_replayer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_axil_rr_replayer;
  import cl_fpgarr_pkg::*;

  localparam int MAXO  = 2;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n, replay_en, log_valid, log_ready;
  logic [AXIL_RR_PKT_W-1:0] log_pkt;
  logic [31:0]              awaddr, wdata, araddr, rdata, rsp_data;
  logic [3:0]               wstrb, wr_outstanding, rd_outstanding;
  logic                     awvalid, awready, wvalid, wready, bvalid, bready;
  logic                     arvalid, arready, rvalid, rready, rsp_valid, rsp_is_read;
  logic [1:0]               bresp, rresp, rsp_resp;
  logic [CNT_W-1:0]         pkt_cnt;
`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
  logic [CNT_W-1:0]         err_cnt;
  logic                     err_sticky;
`endif

  axil_rr_replayer #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .replay_en(replay_en),
    .log_valid(log_valid), .log_ready(log_ready), .log_pkt(log_pkt),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rsp_valid(rsp_valid), .rsp_is_read(rsp_is_read), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .pkt_cnt(pkt_cnt),
`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
    .err_cnt(err_cnt), .err_sticky(err_sticky),
`endif
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one packet in flight, outstanding counts as integers.
  bit          m_live, m_busy, m_rem_aw, m_rem_w, m_rem_ar;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [3:0]  m_wstrb;
  int          m_wr, m_rd;
  logic [31:0] m_pkt_cnt;
  bit          m_rsp_v, m_rsp_rd, m_hold_b;
  logic [31:0] m_rsp_data;
  logic [1:0]  m_rsp_resp, m_hold_resp;
  logic [31:0] m_err;
  bit          m_sticky;
  bit          e_log_ready, e_awvalid, e_wvalid, e_arvalid, e_bready, e_rready;

  // Slave-side bookkeeping for the random responder.
  int s_b_owed, s_r_owed;
  bit b_held, r_held, l_held;

  function automatic void model_reset();
    m_live = 0; m_busy = 0; m_rem_aw = 0; m_rem_w = 0; m_rem_ar = 0;
    m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_araddr = 0;
    m_wr = 0; m_rd = 0; m_pkt_cnt = 0;
    m_rsp_v = 0; m_rsp_rd = 0; m_rsp_data = 0; m_rsp_resp = 0;
    m_hold_b = 0; m_hold_resp = 0; m_err = 0; m_sticky = 0;
    s_b_owed = 0; s_r_owed = 0; b_held = 0; r_held = 0; l_held = 0;
  endfunction

  function automatic void model_outputs();
    e_awvalid   = m_busy && m_rem_aw && (m_wr < MAXO);
    e_wvalid    = m_busy && m_rem_w;
    e_arvalid   = m_busy && m_rem_ar && (m_rd < MAXO);
    e_bready    = m_live && !m_hold_b;
    e_rready    = m_live;
    e_log_ready = m_live && !m_busy && replay_en;
  endfunction

  function automatic logic [AXIL_RR_PKT_W-1:0] mk_pkt(input logic [2:0] hdr, input logic [31:0] aw,
      input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] ar);
    axil_rr_pkt p;
    p.hdr = axil_rr_mstr_hdr'(hdr);
    p.aw.awaddr = aw;
    p.w.wdata = wd;
    p.w.wstrb = ws;
    p.ar.araddr = ar;
    return p;
  endfunction

  task automatic compare_all();
    model_outputs();
    check("log_ready", log_ready, e_log_ready);
    check("awvalid", awvalid, e_awvalid);
    check("wvalid", wvalid, e_wvalid);
    check("arvalid", arvalid, e_arvalid);
    check("bready", bready, e_bready);
    check("rready", rready, e_rready);
    check("awaddr", awaddr, m_awaddr);
    check("wdata", wdata, m_wdata);
    check("wstrb", wstrb, m_wstrb);
    check("araddr", araddr, m_araddr);
    check("rsp_valid", rsp_valid, m_rsp_v);
    if (m_rsp_v) begin
      check("rsp_is_read", rsp_is_read, m_rsp_rd);
      check("rsp_data", rsp_data, m_rsp_data);
      check("rsp_resp", rsp_resp, m_rsp_resp);
    end
    check("pkt_cnt", pkt_cnt, m_pkt_cnt);
    check("wr_outstanding", wr_outstanding, m_wr);
    check("rd_outstanding", rd_outstanding, m_rd);
`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
    check("err_cnt", err_cnt, m_err);
    check("err_sticky", err_sticky, m_sticky);
`endif
  endtask

  // Advance the model over the coming clock edge using the inputs just driven.
  task automatic commit();
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, acc;
    axil_rr_pkt p;
    if (!rst_n) return;
    model_outputs();
    aw_hs = e_awvalid && awready;
    w_hs  = e_wvalid && wready;
    ar_hs = e_arvalid && arready;
    b_hs  = bvalid && e_bready;
    r_hs  = rvalid && e_rready;
    acc   = log_valid && e_log_ready;
    p     = axil_rr_pkt'(log_pkt);

    s_b_owed = s_b_owed + int'(aw_hs) - int'(b_hs);
    if (s_b_owed < 0) s_b_owed = 0;
    s_r_owed = s_r_owed + int'(ar_hs) - int'(r_hs);
    if (s_r_owed < 0) s_r_owed = 0;
    b_held = bvalid && !b_hs;
    r_held = rvalid && !r_hs;
    l_held = log_valid && !acc;

    m_rsp_v = 0;
    if (r_hs) begin
      m_rsp_v = 1; m_rsp_rd = 1; m_rsp_data = rdata; m_rsp_resp = rresp;
      if (b_hs) begin m_hold_b = 1; m_hold_resp = bresp; end
    end else if (m_hold_b) begin
      m_rsp_v = 1; m_rsp_rd = 0; m_rsp_data = 0; m_rsp_resp = m_hold_resp; m_hold_b = 0;
    end else if (b_hs) begin
      m_rsp_v = 1; m_rsp_rd = 0; m_rsp_data = 0; m_rsp_resp = bresp;
    end
    if (b_hs && bresp != 2'b00) begin m_err++; m_sticky = 1; end
    if (r_hs && rresp != 2'b00) begin m_err++; m_sticky = 1; end

    m_wr = m_wr + int'(aw_hs) - int'(b_hs);
    if (m_wr < 0) m_wr = 0;
    m_rd = m_rd + int'(ar_hs) - int'(r_hs);
    if (m_rd < 0) m_rd = 0;

    if (m_busy) begin
      if (aw_hs) m_rem_aw = 0;
      if (w_hs)  m_rem_w  = 0;
      if (ar_hs) m_rem_ar = 0;
      if (!m_rem_aw && !m_rem_w && !m_rem_ar) begin
        m_busy = 0;
        m_pkt_cnt++;
      end
    end else if (acc) begin
      m_awaddr = p.aw.awaddr; m_wdata = p.w.wdata; m_wstrb = p.w.wstrb; m_araddr = p.ar.araddr;
      if (p.hdr == 3'b000) m_pkt_cnt++;
      else begin
        m_busy = 1;
        m_rem_aw = p.hdr.has_aw; m_rem_w = p.hdr.has_w; m_rem_ar = p.hdr.has_ar;
      end
    end
    m_live = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    awready = 1; wready = 1; arready = 1;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
    log_valid = 0; log_pkt = '0;
  endtask

  task automatic drive_random();
    awready = ($urandom_range(0, 3) != 0);
    wready  = ($urandom_range(0, 3) != 0);
    arready = ($urandom_range(0, 3) != 0);
    if (!b_held) begin
      bvalid = (s_b_owed > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
      bresp  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    end
    if (!r_held) begin
      rvalid = (s_r_owed > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 199) == 0);
      rresp  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      rdata  = $urandom;
    end
    if (!l_held) begin
      log_valid = ($urandom_range(0, 1) == 1);
      log_pkt   = mk_pkt(3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom), $urandom);
    end
    if ($urandom_range(0, 49) == 0) replay_en = !replay_en;
  endtask

  initial begin
    rst_n = 0; replay_en = 1;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset bready", bready, 1'b0);
    check("reset rready", rready, 1'b0);
    check("reset log_ready", log_ready, 1'b0);
    check("reset awvalid", awvalid, 1'b0);
    check("reset pkt_cnt", pkt_cnt, 32'd0);
    rst_n = 1;
    commit();

    // Full packet, all channels ready.
    tick();
    check("live log_ready", log_ready, 1'b1);
    log_pkt = mk_pkt(3'b111, 32'h10, 32'hDEADBEEF, 4'hF, 32'h20);
    log_valid = 1;
    commit();
    tick();
    check("p1 awvalid", awvalid, 1'b1);
    check("p1 wvalid", wvalid, 1'b1);
    check("p1 arvalid", arvalid, 1'b1);
    check("p1 awaddr", awaddr, 32'h10);
    check("p1 wdata", wdata, 32'hDEADBEEF);
    check("p1 araddr", araddr, 32'h20);
    check("p1 log_ready", log_ready, 1'b0);
    log_valid = 0;
    commit();
    tick();
    check("p1 done awvalid", awvalid, 1'b0);
    check("p1 pkt_cnt", pkt_cnt, 32'd1);
    check("p1 log_ready back", log_ready, 1'b1);
    check("p1 wr_out", wr_outstanding, 4'd1);
    bvalid = 1; bresp = 2'b00; rvalid = 1; rdata = 32'h1234; rresp = 2'b00;
    commit();
    tick();
    check("collide rsp_valid R", rsp_valid, 1'b1);
    check("collide rsp_is_read", rsp_is_read, 1'b1);
    check("collide rsp_data", rsp_data, 32'h1234);
    check("collide bready", bready, 1'b0);
    bvalid = 0; rvalid = 0;
    commit();
    tick();
    check("collide rsp_valid B", rsp_valid, 1'b1);
    check("collide B is_read", rsp_is_read, 1'b0);
    check("collide B data", rsp_data, 32'h0);
    check("collide bready back", bready, 1'b1);
    check("collide rd_out", rd_outstanding, 4'd0);
    commit();

`ifdef AXIL_RR_REPLAY_ERR_CNT_EN
    // Unsolicited error pair: forwarded, counted, counts saturate at 0.
    tick();
    bvalid = 1; bresp = 2'b10; rvalid = 1; rresp = 2'b11; rdata = 32'h0;
    commit();
    tick();
    check("err pair err_cnt", err_cnt, 32'd2);
    check("err pair sticky", err_sticky, 1'b1);
    check("err pair wr_out", wr_outstanding, 4'd0);
    bvalid = 0; rvalid = 0;
    commit();
    tick();
    bvalid = 1; bresp = 2'b00;
    commit();
    tick();
    bvalid = 0;
    commit();
    tick();
    check("okay keeps err_cnt", err_cnt, 32'd2);
    check("okay keeps sticky", err_sticky, 1'b1);
    commit();
`endif

    // AW stalled for 5 cycles; second (empty) packet must wait behind it.
    tick();
    log_pkt = mk_pkt(3'b110, 32'h44, 32'h55, 4'h3, 32'h0);
    log_valid = 1; awready = 0; wready = 1;
    commit();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall awvalid", awvalid, 1'b1);
      check("stall awaddr", awaddr, 32'h44);
      check("stall log_ready", log_ready, 1'b0);
      if (i == 1) check("stall w done", wvalid, 1'b0);
      if (i == 0) log_pkt = mk_pkt(3'b000, 32'h99, 32'h0, 4'h0, 32'h0);
      if (i == 4) awready = 1;
      commit();
    end
    tick();
    check("stall pkt_cnt", pkt_cnt, 32'd2);
    check("stall next accepted", log_ready, 1'b1);
    commit();
    tick();
    check("empty pkt_cnt", pkt_cnt, 32'd3);
    check("empty log_ready", log_ready, 1'b1);
    check("empty awvalid", awvalid, 1'b0);
    log_valid = 0; bvalid = 1; bresp = 2'b00;
    commit();
    tick();
    bvalid = 0;
    commit();

    // Outstanding limit: third write-only packet waits for a B.
    tick();
    log_pkt = mk_pkt(3'b100, 32'h100, 32'h0, 4'h0, 32'h0);
    log_valid = 1;
    commit();
    repeat (8) begin tick(); commit(); end
    tick();
    check("limit wr_out", wr_outstanding, 4'd2);
    check("limit awvalid", awvalid, 1'b0);
    check("limit log_ready", log_ready, 1'b0);
    check("limit pkt_cnt", pkt_cnt, 32'd5);
    log_valid = 0; bvalid = 1; bresp = 2'b00;
    commit();
    tick();
    check("limit released awvalid", awvalid, 1'b1);
    check("limit released wr_out", wr_outstanding, 4'd1);
    bvalid = 0;
    commit();
    tick();
    check("limit reissue pkt_cnt", pkt_cnt, 32'd6);
    check("limit reissue wr_out", wr_outstanding, 4'd2);
    commit();

    // Reset in the middle of an ISSUE.
    tick();
    log_pkt = mk_pkt(3'b111, 32'h200, 32'h1, 4'h1, 32'h300);
    log_valid = 1; awready = 0; wready = 0; arready = 0;
    commit();
    tick();
    log_valid = 0;
    commit();
    tick();
    check("mid wvalid", wvalid, 1'b1);
    check("mid arvalid", arvalid, 1'b1);
    rst_n = 0;
    #1;
    check("async rst wvalid", wvalid, 1'b0);
    check("async rst arvalid", arvalid, 1'b0);
    check("async rst wr_out", wr_outstanding, 4'd0);
    check("async rst pkt_cnt", pkt_cnt, 32'd0);
    check("async rst bready", bready, 1'b0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    commit();

    repeat (4000) begin
      tick();
      drive_random();
      commit();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
